// File: rtl/wb_reg_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one 32-bit register slave segment,
// with a stall timeout that aborts cycles the slaves never acknowledge.
module wb_reg_arbiter #(
  parameter int unsigned C_NUM_MASTERS = 4,
  parameter int unsigned C_TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [C_NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [C_NUM_MASTERS-1:0]      m_stb_i,
  input  logic [C_NUM_MASTERS-1:0]      m_we_i,
  input  logic [4*C_NUM_MASTERS-1:0]    m_sel_i,
  input  logic [32*C_NUM_MASTERS-1:0]   m_adr_i,
  input  logic [32*C_NUM_MASTERS-1:0]   m_dat_i,
  output logic [31:0]                   m_dat_o,
  output logic [C_NUM_MASTERS-1:0]      m_ack_o,
  output logic [C_NUM_MASTERS-1:0]      m_err_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [3:0]                    s_sel_o,
  output logic [31:0]                   s_adr_o,
  output logic [31:0]                   s_dat_o,
  input  logic [31:0]                   s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  output logic [C_NUM_MASTERS-1:0]      grant_o
);

  localparam int unsigned N  = C_NUM_MASTERS;
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(C_TIMEOUT - 1);

  logic [1:0]    state;
  logic [N-1:0]  grant;
  logic [LW-1:0] last;
  logic [15:0]   to_cnt;

  logic          win_found;
  logic [LW-1:0] win_idx;
  logic [LW-1:0] cand;

  logic          own_cyc;
  logic          own_stb;
  logic          own_we;
  logic [3:0]    own_sel;
  logic [31:0]   own_adr;
  logic [31:0]   own_dat;

  logic          owning;
  logic          timeout_hit;

  // Round-robin search starting just after the previous owner, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = LW'((32'(last) + 32'd1 + i) % N);
      if (!win_found && m_cyc_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // AND-OR mux on the registered one-hot grant; all zero when nobody owns the bus.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        own_cyc = own_cyc | m_cyc_i[i];
        own_stb = own_stb | m_stb_i[i];
        own_we  = own_we  | m_we_i[i];
        own_sel = own_sel | m_sel_i[4*i +: 4];
        own_adr = own_adr | m_adr_i[32*i +: 32];
        own_dat = own_dat | m_dat_i[32*i +: 32];
      end
    end
  end

  assign owning      = (state == ST_OWN);
  // An ack or err in the final stalled cycle takes precedence over the abort.
  assign timeout_hit = owning && own_cyc && own_stb && !s_ack_i && !s_err_i &&
                       (to_cnt == TO_LAST);

  assign s_cyc_o = owning & own_cyc;
  assign s_stb_o = owning & own_stb;
  assign s_we_o  = own_we;
  assign s_sel_o = own_sel;
  assign s_adr_o = own_adr;
  assign s_dat_o = own_dat;

  assign m_ack_o = owning ? (grant & {N{s_ack_i}}) : '0;
  assign m_err_o = owning ? (grant & {N{s_err_i | timeout_hit}}) : '0;
  assign m_dat_o = (|grant) ? s_dat_i : '0;
  assign grant_o = grant;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      grant  <= '0;
      last   <= LW'(N - 1);
      to_cnt <= '0;
    end else begin
      to_cnt <= (!s_stb_o || s_ack_i || s_err_i) ? '0 : to_cnt + 16'd1;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state <= ST_OWN;
            grant <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            last  <= win_idx;
          end else begin
            grant <= '0;
          end
        end
        ST_OWN: begin
          if (!own_cyc) begin
            state <= ST_IDLE;
            grant <= '0;
          end else if (timeout_hit) begin
            state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (!own_cyc) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_reg_arbiter.sv
// Scoreboard bench for wb_reg_arbiter: directed master transfers against a
// delay-programmable register-slave model, with grant/response/slave monitors.
module tb_wb_reg_arbiter;

  localparam int N = 4;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [4*N-1:0]    m_sel_i;
  logic [32*N-1:0]   m_adr_i, m_dat_i;
  logic [31:0]       m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o, grant_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_adr_o, s_dat_o, s_dat_i;
  logic              s_ack_i, s_err_i;

  wb_reg_arbiter #(.C_NUM_MASTERS(N), .C_TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Per-master drive state, packed into the flattened DUT vectors.
  logic        mcyc[N], mstb[N], mwe[N];
  logic [3:0]  msel[N];
  logic [31:0] madr[N], mdat[N];

  always_comb begin
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    for (int k = 0; k < N; k++) begin
      m_cyc_i[k] = mcyc[k];
      m_stb_i[k] = mstb[k];
      m_we_i[k]  = mwe[k];
      m_sel_i[4*k +: 4]   = msel[k];
      m_adr_i[32*k +: 32] = madr[k];
      m_dat_i[32*k +: 32] = mdat[k];
    end
  end

  // Slave model: responds after ack_delay stalled cycles of s_stb_o.
  int unsigned ack_delay = 1;
  bit          slv_err   = 1'b0;
  logic [7:0]  sc        = '0;

  always @(posedge wb_clk_i) sc <= (!s_stb_o || s_ack_i || s_err_i) ? 8'd0 : sc + 8'd1;
  assign s_ack_i = s_stb_o && (32'(sc) == ack_delay) && !slv_err;
  assign s_err_i = s_stb_o && (32'(sc) == ack_delay) && slv_err;
  assign s_dat_i = s_adr_o ^ 32'hDEAD_BEEF;

  typedef struct {
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic [31:0]  dat;
    bit           chk_dat;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } slv_t;

  rsp_t         rsp_q[$];
  slv_t         slv_q[$];
  logic [N-1:0] gnt_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_rsp(input int k, input bit is_err, input logic [31:0] dat, input bit chkd);
    rsp_t r;
    logic [N-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    r.ack = is_err ? '0 : oh;
    r.err = is_err ? oh : '0;
    r.dat = dat;
    r.chk_dat = chkd;
    rsp_q.push_back(r);
  endtask

  task automatic exp_slv(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat);
    slv_t s;
    s.we = we; s.sel = sel; s.adr = adr; s.dat = dat;
    slv_q.push_back(s);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, m_ack_o, m_err_o, grant_o}), 64'd0);
    chk({tag, "_sbus"}, 64'({s_adr_o, s_dat_o}), 64'd0);
    chk({tag, "_mdat"}, 64'(m_dat_o), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Single or burst transfer by master k; caller starts just after a rising edge.
  task automatic mxfer(input int k, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat, input int beats);
    int n;
    mwe[k] = we; msel[k] = sel; madr[k] = adr; mdat[k] = dat;
    mcyc[k] = 1'b1; mstb[k] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      n = 0;
      @(negedge wb_clk_i);
      while (!(m_ack_o[k] || m_err_o[k]) && n < 100) begin
        @(negedge wb_clk_i);
        n++;
      end
      chk("resp_wait", 64'(n < 100), 64'd1);
      @(posedge wb_clk_i);
      #1;
      madr[k] = madr[k] + 32'd4;
      mdat[k] = mdat[k] + 32'd1;
    end
    mstb[k] = 1'b0; mcyc[k] = 1'b0; mwe[k] = 1'b0;
  endtask

  // Monitors: grant rises, master responses and slave-side transfers.
  logic [N-1:0] prev_g = '0;
  rsp_t         mon_r;
  slv_t         mon_s;

  always @(negedge wb_clk_i) begin
    if (grant_o !== prev_g) begin
      if (grant_o != '0) begin
        chk("dead_cycle", 64'(prev_g), 64'd0);
        if (gnt_q.size() == 0) chk("grant_extra", 64'(grant_o), 64'd0);
        else chk("grant", 64'(grant_o), 64'(gnt_q.pop_front()));
      end
      prev_g = grant_o;
    end
    if ((m_ack_o | m_err_o) != '0) begin
      chk("resp_owner", 64'((m_ack_o | m_err_o) & ~grant_o), 64'd0);
      if (rsp_q.size() == 0) chk("resp_extra", 64'(m_ack_o | m_err_o), 64'd0);
      else begin
        mon_r = rsp_q.pop_front();
        chk("ack", 64'(m_ack_o), 64'(mon_r.ack));
        chk("err", 64'(m_err_o), 64'(mon_r.err));
        if (mon_r.chk_dat) chk("rdata", 64'(m_dat_o), 64'(mon_r.dat));
      end
    end
    if (s_stb_o && (s_ack_i || s_err_i)) begin
      chk("slv_cyc", 64'(s_cyc_o), 64'd1);
      if (slv_q.size() == 0) chk("slv_extra", 64'(s_adr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        mon_s = slv_q.pop_front();
        chk("slv_ctl", 64'({s_we_o, s_sel_o}), 64'({mon_s.we, mon_s.sel}));
        chk("slv_adr", 64'(s_adr_o), 64'(mon_s.adr));
        chk("slv_dat", 64'(s_dat_o), 64'(mon_s.dat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wb_rst_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      mcyc[k] = 1'b0; mstb[k] = 1'b0; mwe[k] = 1'b0;
      msel[k] = '0; madr[k] = '0; mdat[k] = '0;
    end
    #3;
    chk_zero("reset");
    idle(2);
    wb_rst_i = 1'b0;
    idle(2);

    // All four masters compete; master 0 comes back for a second transfer.
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
    exp_rsp(0, 0, 32'hDEAD_BEFF, 1); exp_slv(0, 4'hF, 32'h10, 32'h0);
    exp_rsp(1, 0, 32'hDEAD_BECF, 1); exp_slv(0, 4'hF, 32'h20, 32'h0);
    exp_rsp(2, 0, 32'hDEAD_BEDF, 1); exp_slv(0, 4'hF, 32'h30, 32'h0);
    exp_rsp(3, 0, 32'hDEAD_BEAF, 1); exp_slv(0, 4'hF, 32'h40, 32'h0);
    exp_rsp(0, 0, 32'hDEAD_BEBF, 1); exp_slv(0, 4'hF, 32'h50, 32'h0);
    fork
      begin
        mxfer(0, 1'b0, 4'hF, 32'h10, 32'h0, 1);
        @(posedge wb_clk_i); #1;
        mxfer(0, 1'b0, 4'hF, 32'h50, 32'h0, 1);
      end
      mxfer(1, 1'b0, 4'hF, 32'h20, 32'h0, 1);
      mxfer(2, 1'b0, 4'hF, 32'h30, 32'h0, 1);
      mxfer(3, 1'b0, 4'hF, 32'h40, 32'h0, 1);
    join
    idle(3);

    // Single master 0 read with cycle-accurate latency checks, then a slave error.
    gnt_q.push_back(4'b0001);
    exp_rsp(0, 0, 32'hDEAD_BEEF, 1); exp_slv(0, 4'hF, 32'h0, 32'h0);
    fork
      mxfer(0, 1'b0, 4'hF, 32'h0, 32'h0, 1);
      begin
        @(negedge wb_clk_i);
        chk("grant_before_edge", 64'(grant_o), 64'd0);
        @(negedge wb_clk_i);
        chk("grant_latency", 64'(grant_o), 64'b0001);
        chk("stb_latency", 64'({s_cyc_o, s_stb_o}), 64'b11);
        chk("ack_not_yet", 64'(m_ack_o), 64'd0);
        @(negedge wb_clk_i);
        chk("ack_latency", 64'(m_ack_o), 64'b0001);
        chk("rdata_deadbeef", 64'(m_dat_o), 64'hDEAD_BEEF);
      end
    join
    idle(2);
    slv_err = 1'b1;
    gnt_q.push_back(4'b0001);
    exp_rsp(0, 1, 32'h0, 0); exp_slv(0, 4'hF, 32'h4, 32'h0);
    mxfer(0, 1'b0, 4'hF, 32'h4, 32'h0, 1);
    slv_err = 1'b0;
    idle(3);

    // Master 2 burst of three writes is not interrupted by master 1.
    gnt_q.push_back(4'b0100); gnt_q.push_back(4'b0010);
    exp_rsp(2, 0, 32'h0, 0); exp_slv(1, 4'hF, 32'h100, 32'h1111_0000);
    exp_rsp(2, 0, 32'h0, 0); exp_slv(1, 4'hF, 32'h104, 32'h1111_0001);
    exp_rsp(2, 0, 32'h0, 0); exp_slv(1, 4'hF, 32'h108, 32'h1111_0002);
    exp_rsp(1, 0, 32'h0, 0); exp_slv(1, 4'h3, 32'h200, 32'h2222_0000);
    fork
      mxfer(2, 1'b1, 4'hF, 32'h100, 32'h1111_0000, 3);
      begin
        @(posedge wb_clk_i); #1;
        mxfer(1, 1'b1, 4'h3, 32'h200, 32'h2222_0000, 1);
      end
    join
    idle(3);

    // Slave never answers: abort err on the 8th stalled cycle.
    ack_delay = 1000;
    gnt_q.push_back(4'b0010);
    exp_rsp(1, 1, 32'h0, 0);
    mwe[1] = 1'b0; msel[1] = 4'hF; madr[1] = 32'h300; mdat[1] = '0;
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    n = 0;
    @(negedge wb_clk_i);
    while (!s_stb_o && n < 20) begin @(negedge wb_clk_i); n++; end
    chk("stb_rise_wait", 64'(n < 20), 64'd1);
    n = 1;
    while (m_err_o == '0 && n < 40) begin @(negedge wb_clk_i); n++; end
    chk("abort_latency", 64'(n), 64'd8);
    @(negedge wb_clk_i);
    chk("abort_bus_low", 64'({s_cyc_o, s_stb_o}), 64'd0);
    chk("abort_grant", 64'(grant_o), 64'b0010);
    @(posedge wb_clk_i); #1;
    mstb[1] = 1'b0;
    @(posedge wb_clk_i); #1;
    mcyc[1] = 1'b0;
    @(negedge wb_clk_i);
    chk("abort_hold", 64'({grant_o, m_ack_o, m_err_o}), 64'({4'b0010, 4'b0, 4'b0}));
    @(negedge wb_clk_i);
    chk("abort_release", 64'(grant_o), 64'd0);
    idle(2);

    // Slave answers exactly on the timeout cycle: ack wins, bus stays owned.
    ack_delay = 7;
    gnt_q.push_back(4'b0100);
    exp_rsp(2, 0, 32'hDEAD_BEE7, 1); exp_slv(0, 4'hF, 32'h8, 32'h0);
    mwe[2] = 1'b0; msel[2] = 4'hF; madr[2] = 32'h8; mdat[2] = '0;
    mcyc[2] = 1'b1; mstb[2] = 1'b1;
    n = 0;
    @(negedge wb_clk_i);
    while (!s_stb_o && n < 20) begin @(negedge wb_clk_i); n++; end
    chk("stb_rise_wait2", 64'(n < 20), 64'd1);
    n = 1;
    while ((m_ack_o | m_err_o) == '0 && n < 40) begin @(negedge wb_clk_i); n++; end
    chk("late_ack_latency", 64'(n), 64'd8);
    chk("late_ack_no_err", 64'(m_err_o), 64'd0);
    @(posedge wb_clk_i); #1;
    mstb[2] = 1'b0;
    @(negedge wb_clk_i);
    chk("late_ack_own", 64'({grant_o, s_cyc_o}), 64'({4'b0100, 1'b1}));
    @(posedge wb_clk_i); #1;
    mcyc[2] = 1'b0;
    idle(3);

    // Reset in the middle of a stalled master 3 cycle.
    ack_delay = 1000;
    gnt_q.push_back(4'b1000);
    mwe[3] = 1'b0; msel[3] = 4'hF; madr[3] = 32'h400; mdat[3] = '0;
    mcyc[3] = 1'b1; mstb[3] = 1'b1;
    n = 0;
    @(negedge wb_clk_i);
    while (!s_stb_o && n < 20) begin @(negedge wb_clk_i); n++; end
    chk("stb_rise_wait3", 64'(n < 20), 64'd1);
    repeat (3) @(negedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk_zero("midrst");
    mcyc[3] = 1'b0; mstb[3] = 1'b0;
    idle(2);
    wb_rst_i = 1'b0;
    ack_delay = 1;
    idle(1);
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b1000);
    exp_rsp(0, 0, 32'hDEAD_BBEF, 1); exp_slv(0, 4'hF, 32'h500, 32'h0);
    exp_rsp(3, 0, 32'hDEAD_B8EF, 1); exp_slv(0, 4'hF, 32'h600, 32'h0);
    fork
      mxfer(0, 1'b0, 4'hF, 32'h500, 32'h0, 1);
      mxfer(3, 1'b0, 4'hF, 32'h600, 32'h0, 1);
    join
    idle(5);

    chk("grant_queue_drained", 64'(gnt_q.size()), 64'd0);
    chk("resp_queue_drained", 64'(rsp_q.size()), 64'd0);
    chk("slave_queue_drained", 64'(slv_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
